// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer: operation modes and FSM states.
package shift_seq_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Left-moving modes emit the MSB, right-moving modes emit the LSB.
    function automatic logic mode_is_left(input logic [1:0] m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit register built from per-bit DFF stages with async active-low clear.
// Provides the post-shift value so the controller can capture the final result.
module shift_reg_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             ser_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = q_q;
        unique case (mode)
            MODE_SHL: shifted = {q_q[WIDTH-2:0], ser_in};
            MODE_SHR: shifted = {ser_in, q_q[WIDTH-1:1]};
            MODE_ROL: shifted = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR: shifted = {q_q[0], q_q[WIDTH-1:1]};
            default:  shifted = q_q;
        endcase
    end

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
            q_d = shifted;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_q[i] <= 1'b0;
            end else begin
                q_q[i] <= q_d[i];
            end
        end
    end

    assign q       = q_q;
    assign q_next  = shifted;
    assign ser_out = mode_is_left(mode) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: accepts a word, runs WIDTH shift/rotate steps at one step per DIV
// cycles, then holds the result until the consumer accepts it.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and dout_valid holds until taken.

    localparam int DCW = $clog2(DIV + 1);
    localparam int SCW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [SCW-1:0]   step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             start_fire;
    logic             last_step;
    logic [WIDTH-1:0] core_q_next;
    logic             core_ser_out;

    assign start_fire = start_valid && (state_q == ST_IDLE);
    assign shift_en   = (state_q == ST_SHIFT) && (div_cnt_q == DCW'(DIV - 1));
    assign last_step  = shift_en && (step_cnt_q == SCW'(WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        dout_d     = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d    = ST_SHIFT;
                    mode_d     = mode;
                    div_cnt_d  = '0;
                    step_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    div_cnt_d  = '0;
                    step_cnt_d = step_cnt_q + 1'b1;
                    if (last_step) begin
                        state_d = ST_DONE;
                        dout_d  = core_q_next;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (dout_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SHL;
            div_cnt_q  <= '0;
            step_cnt_q <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            div_cnt_q  <= div_cnt_d;
            step_cnt_q <= step_cnt_d;
            dout_q     <= dout_d;
        end
    end

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (reset),
        .load      (start_fire),
        .load_data (din),
        .shift     (shift_en),
        .mode      (mode_q),
        .ser_in    (ser_in),
        .q         (q),
        .q_next    (core_q_next),
        .ser_out   (core_ser_out)
    );

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign dout_valid  = (state_q == ST_DONE);
    assign dout        = dout_q;
    assign ser_out     = (state_q == ST_SHIFT) ? core_ser_out : 1'b0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: DIV=1 and DIV=3 instances, directed vectors,
// scoreboard queues for ser_out, dout and result latency.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       start_valid, start_ready, ser_in, ser_out, shift_en;
    logic [1:0]       busy, dout_valid, dout_ready, dv_prev;
    logic [W-1:0]     din [2];
    logic [W-1:0]     q [2];
    logic [W-1:0]     dout [2];
    logic [1:0]       mode [2];
    logic [1:0]       dbg [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic         exp_ser_q[$];
    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    shift_seq_ctrl #(.WIDTH(W), .DIV(1)) dut1 (
        .clk(clk), .reset(rst_n), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .din(din[0]), .mode(mode[0]), .ser_in(ser_in[0]), .ser_out(ser_out[0]),
        .shift_en(shift_en[0]), .q(q[0]), .busy(busy[0]), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]), .dbg_state(dbg[0])
    );

    shift_seq_ctrl #(.WIDTH(W), .DIV(3)) dut3 (
        .clk(clk), .reset(rst_n), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .din(din[1]), .mode(mode[1]), .ser_in(ser_in[1]), .ser_out(ser_out[1]),
        .shift_en(shift_en[1]), .q(q[1]), .busy(busy[1]), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]), .dbg_state(dbg[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Monitor: pops expectations whenever a DUT presents a shift step or result.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (start_valid[d] && start_ready[d])
                    lat_q.push_back(cyc + W * div_of(d) + 1);
                if (shift_en[d]) begin
                    if (exp_ser_q.size() == 0) timeout_fail("ser_out_unexpected_shift");
                    else check("ser_out", W'(ser_out[d]), W'(exp_ser_q.pop_front()));
                end
                if (dout_valid[d] && !dv_prev[d]) begin
                    if (lat_q.size() == 0) timeout_fail("dout_valid_unexpected");
                    else check_int("dout_valid_latency", cyc, lat_q.pop_front());
                end
                if (dout_valid[d] && dout_ready[d]) begin
                    if (exp_q.size() == 0) timeout_fail("dout_unexpected");
                    else check("dout", dout[d], exp_q.pop_front());
                end
            end
        end
        dv_prev <= dout_valid;
    end

    task automatic wait_shift(input int d, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (shift_en[d]) begin
                ok = 1'b1;
                return;
            end
        end
        timeout_fail("wait_shift_en");
    endtask

    task automatic wait_idle(input int d);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy[d] && start_ready[d]) return;
        end
        timeout_fail("wait_idle");
    endtask

    // s[i] is the ser_in bit for step i, e[i] the ser_out bit expected at step i.
    task automatic run_op(input int d, input logic [W-1:0] dv, input logic [1:0] m,
                          input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] expd);
        bit ok;
        int prev;
        prev = 0;
        for (int i = 0; i < W; i++) exp_ser_q.push_back(e[i]);
        exp_q.push_back(expd);
        @(posedge clk); #1;
        start_valid[d] = 1'b1;
        din[d] = dv;
        mode[d] = m;
        ser_in[d] = s[0];
        @(posedge clk); #1;
        start_valid[d] = 1'b0;
        din[d] = ~dv;
        mode[d] = ~m;
        for (int i = 0; i < W; i++) begin
            wait_shift(d, ok);
            if (!ok) return;
            if (i > 0) check_int("shift_en_spacing", cyc - prev, div_of(d));
            prev = cyc;
            @(posedge clk); #1;
            if (i < W - 1) ser_in[d] = s[i + 1];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        start_valid = '0;
        ser_in = '0;
        dout_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            din[d] = '0;
            mode[d] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_start_ready", W'(start_ready[d]), W'(1));
            check("rst_busy", W'(busy[d]), W'(0));
            check("rst_dout_valid", W'(dout_valid[d]), W'(0));
            check("rst_shift_en", W'(shift_en[d]), W'(0));
            check("rst_ser_out", W'(ser_out[d]), W'(0));
            check("rst_q", q[d], 4'b0000);
            check("rst_dout", dout[d], 4'b0000);
        end
        #2 rst_n = 1'b1;

        run_op(0, 4'b1011, MODE_ROL, 4'b0000, 4'b1101, 4'b1011);
        wait_idle(0);
        run_op(0, 4'b1001, MODE_SHL, 4'b1011, 4'b1001, 4'b1101);
        wait_idle(0);
        run_op(0, 4'b0110, MODE_SHR, 4'b0000, 4'b0110, 4'b0000);
        wait_idle(0);
        run_op(0, 4'b0110, MODE_ROR, 4'b0000, 4'b0110, 4'b0110);
        wait_idle(0);
        run_op(1, 4'b1000, MODE_SHL, 4'b0000, 4'b0001, 4'b0000);
        wait_idle(1);

        // Result held while the consumer stalls; starts are refused.
        dout_ready[0] = 1'b0;
        run_op(0, 4'b0101, MODE_ROL, 4'b0000, 4'b1010, 4'b0101);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = dout_valid[0];
        end
        if (!ok) timeout_fail("hold_wait_dout_valid");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start_valid[0] = 1'b1;
            din[0] = 4'b1111;
            mode[0] = MODE_SHL;
            @(negedge clk);
            check("hold_dout_valid", W'(dout_valid[0]), W'(1));
            check("hold_dout", dout[0], 4'b0101);
            check("hold_start_ready", W'(start_ready[0]), W'(0));
            check("hold_q", q[0], 4'b0101);
            check("hold_state", W'(dbg[0]), W'(ST_DONE));
        end
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        dout_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_start_ready", W'(start_ready[0]), W'(1));
        check("release_dout_valid", W'(dout_valid[0]), W'(0));
        check("release_q", q[0], 4'b0101);

        // Asynchronous reset during step 2 aborts the operation.
        exp_ser_q.push_back(1'b1);
        exp_ser_q.push_back(1'b0);
        @(posedge clk); #1;
        start_valid[0] = 1'b1;
        din[0] = 4'b1011;
        mode[0] = MODE_SHL;
        ser_in[0] = 1'b1;
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        wait_shift(0, ok);
        if (ok) wait_shift(0, ok);
        #1 rst_n = 1'b0;
        #1;
        check("abort_q", q[0], 4'b0000);
        check("abort_busy", W'(busy[0]), W'(0));
        check("abort_start_ready", W'(start_ready[0]), W'(1));
        check("abort_dout_valid", W'(dout_valid[0]), W'(0));
        check("abort_shift_en", W'(shift_en[0]), W'(0));
        exp_ser_q.delete();
        exp_q.delete();
        lat_q.delete();
        ser_in[0] = 1'b0;
        @(negedge clk);
        check("abort_dout_valid_held", W'(dout_valid[0]), W'(0));
        #2 rst_n = 1'b1;

        run_op(0, 4'b1011, MODE_ROL, 4'b0000, 4'b1101, 4'b1011);
        wait_idle(0);
        repeat (2) @(negedge clk);

        check_int("ser_queue_empty", exp_ser_q.size(), 0);
        check_int("dout_queue_empty", exp_q.size(), 0);
        check_int("latency_queue_empty", lat_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the team's 4-bit D-flip-flop shift register. Accepts a parallel word over a valid/ready handshake, loads it, and runs exactly WIDTH shift or rotate steps at a programmable rate while streaming bits out on ser_out and capturing ser_in. It then presents the final register contents over an output valid/ready handshake. It sits between a host or control FSM and a serial link or chain of DFF stages.

Parameters:
WIDTH, 4, register width and number of shift steps per operation (legal range >= 2)
DIV, 1, clock cycles per shift step (legal range >= 1); counter width is $clog2(DIV+1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low; 0 clears all state immediately
start_valid  input  1  host offers a new operation
start_ready  output  1  controller can accept; high only in IDLE
din  input  WIDTH  parallel load word, sampled on start handshake
mode  input  2  00 shift-left, 01 shift-right, 10 rotate-left, 11 rotate-right; sampled on start handshake
ser_in  input  1  serial fill bit, sampled on each shift edge (shift modes only)
ser_out  output  1  bit leaving the register this step
shift_en  output  1  high in each cycle whose closing edge performs a shift
q  output  WIDTH  live register contents
busy  output  1  high in SHIFT or DONE
dout  output  WIDTH  result word, valid while dout_valid
dout_valid  output  1  result available
dout_ready  input  1  consumer accepts result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; q, dout, shift counter, div counter and latched mode = 0. Outputs: start_ready=1, busy=0, dout_valid=0, shift_en=0, ser_out=0. Reset mid-operation aborts with no result produced.
- States: IDLE, SHIFT, DONE.
- IDLE: start_ready=1. A handshake (start_valid & start_ready) in cycle T loads q<=din and latches mode; the next state is SHIFT with div_cnt=0 and step_cnt=0. Without a handshake the block stays in IDLE and q holds.
- SHIFT:
  - shift_en = (div_cnt==DIV-1). div_cnt increments each cycle and wraps to 0 on a shift.
  - On a shift edge, step_cnt increments and q updates:
    - left: q<={q[W-2:0],ser_in}
    - right: q<={ser_in,q[W-1:1]}
    - rotate-left: q<={q[W-2:0],q[W-1]}
    - rotate-right: q<={q[0],q[W-1:1]}
  - ser_out = q[W-1] for left/rotate-left, q[0] for right/rotate-right. It is combinational and valid for the whole step.
  - On the shift edge where step_cnt==WIDTH-1, the next state is DONE and dout<=the post-shift q value.
- Latency with DIV=1: handshake in cycle T, shifts on the edges closing cycles T+1..T+WIDTH, dout_valid=1 from cycle T+WIDTH+1. In general, dout_valid=1 from cycle T+WIDTH*DIV+1.
- DONE: dout_valid=1. dout and q are held stable and ser_out=0.
  - dout_valid & dout_ready -> IDLE on the next edge.
  - dout_valid stays asserted until accepted; there is no timeout and no overwrite.
- start_valid outside IDLE is ignored, since start_ready=0. din and mode changes during SHIFT have no effect.
- If dout_ready is held high, a new start can be accepted no earlier than the cycle after the DONE->IDLE transition; there is no bypass.
- ser_out=0 and shift_en=0 in IDLE and DONE.

Decomposition:
- Package shift_seq_pkg holds:
  - mode encodings MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_ROL=2'b10, MODE_ROR=2'b11
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
- Sub-module shift_reg_core contains the WIDTH-bit register built from DFF-style stages with asynchronous active-low clear.
  - Inputs: load, load_data, shift, mode, ser_in.
  - Outputs: q, ser_out.
  - The controller holds the FSM and counters only.

Test Plan:
- Reset, then start din=4'b1011, mode=10, DIV=1 -> ser_out sequence 1,0,1,1; shift_en high for exactly 4 cycles; dout=4'b1011; dout_valid in cycle T+5.
- Start din=4'b1001, mode=00, ser_in=1,1,0,1 on successive shift edges -> ser_out 1,0,0,1; dout=4'b1101.
- Start din=4'b0110, mode=01, ser_in=0 -> ser_out 0,1,1,0; dout=4'b0000. Repeat with mode=11 -> dout=4'b0110.
- DIV=3, din=4'b1000, mode=00 -> shift_en pulses every 3rd cycle; dout_valid at T+13; dout=4'b0000 when ser_in=0.
- Hold dout_ready=0 for 10 cycles in DONE while pulsing start_valid -> dout_valid and dout stay stable, start_ready=0, no new load. Raise dout_ready -> IDLE next cycle.
- Assert reset=0 asynchronously at step 2 of a shift operation -> q=0, busy=0, start_ready=1 immediately, no dout_valid pulse. Release reset and run a new operation normally.
